// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the ALU's internal operation encoding.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_PASS_B,
    ALU_ZERO
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left logical, right logical or right arithmetic.
module alu_shifter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         data,
  input  logic [$clog2(XLEN)-1:0] amt,
  input  logic                    dir,
  input  logic                    arith,
  output logic [XLEN-1:0]         result
);

  logic signed [XLEN-1:0] data_s;

  assign data_s = data;

  // dir = 1 shifts right; arith only matters for right shifts.
  always_comb begin
    result = data << amt;
    if (dir) begin
      if (arith) result = data_s >>> amt;
      else       result = data >> amt;
    end
  end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: opcode/funct decode, datapath, branch compare flags,
// all registered for a single cycle of latency.
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         A,
  input  logic [XLEN-1:0]         B,
  input  logic [2:0]              func3,
  input  logic [6:0]              func7,
  input  logic [6:0]              opcode,
  input  logic [$clog2(XLEN)-1:0] shamt,
  output logic [XLEN-1:0]         Q,
  output logic                    EQ,
  output logic                    EQM,
  output logic                    EQM_U
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e                op;
  logic                   use_shamt;
  logic [SHW-1:0]         shift_amt;
  logic [XLEN-1:0]        shift_res;
  logic [XLEN-1:0]        result;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   eq;
  logic                   lt;
  logic                   ltu;
  logic                   unused_func7;

  logic [XLEN-1:0]        q_p1;
  logic                   eq_p1;
  logic                   lt_p1;
  logic                   ltu_p1;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  // R-type and OP-IMM share the func3 map; OP-IMM never subtracts.
  always_comb begin
    op        = ALU_ZERO;
    use_shamt = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        use_shamt = (opcode == OPC_OPIMM);
        case (func3)
          F3_ADD_SUB: op = (opcode == OPC_OP && func7[5]) ? ALU_SUB : ALU_ADD;
          F3_SLL:     op = ALU_SLL;
          F3_SLT:     op = ALU_SLT;
          F3_SLTU:    op = ALU_SLTU;
          F3_XOR:     op = ALU_XOR;
          F3_SRL_SRA: op = func7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      op = ALU_OR;
          F3_AND:     op = ALU_AND;
          default:    op = ALU_ZERO;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL, OPC_AUIPC: op = ALU_ADD;
      OPC_LUI:    op = ALU_PASS_B;
      OPC_BRANCH: op = ALU_SUB;
      default:    op = ALU_ZERO;
    endcase
  end

  assign shift_amt = use_shamt ? shamt : B[SHW-1:0];

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .data   (A),
    .amt    (shift_amt),
    .dir    (op == ALU_SRL || op == ALU_SRA),
    .arith  (op == ALU_SRA),
    .result (shift_res)
  );

  assign a_s = A;
  assign b_s = B;
  assign eq  = (A == B);
  assign lt  = (a_s < b_s);
  assign ltu = (A < B);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = A + B;
      ALU_SUB:    result = A - B;
      ALU_AND:    result = A & B;
      ALU_OR:     result = A | B;
      ALU_XOR:    result = A ^ B;
      ALU_SLL, ALU_SRL, ALU_SRA: result = shift_res;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, ltu};
      ALU_PASS_B: result = B;
      default:    result = '0;
    endcase
  end

  // ---- stage p1: registered result and flags ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_p1   <= '0;
      eq_p1  <= 1'b0;
      lt_p1  <= 1'b0;
      ltu_p1 <= 1'b0;
    end else begin
      q_p1   <= result;
      eq_p1  <= eq;
      lt_p1  <= lt;
      ltu_p1 <= ltu;
    end
  end

  assign Q     = q_p1;
  assign EQ    = eq_p1;
  assign EQM   = lt_p1;
  assign EQM_U = ltu_p1;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized back-to-back traffic
// compared against a behavioural RV32I reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [6:0]  opcode;
  logic [4:0]  shamt;
  logic [31:0] Q;
  logic        EQ, EQM, EQM_U;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_q;
  logic [2:0]  prev_flags;

  always #5 clk = ~clk;

  alu #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .func3  (func3),
    .func7  (func7),
    .opcode (opcode),
    .shamt  (shamt),
    .Q      (Q),
    .EQ     (EQ),
    .EQM    (EQM),
    .EQM_U  (EQM_U)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Architectural result of one RV32I instruction's ALU operation.
  function automatic logic [31:0] ref_q(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] sh,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    longint sav, sbv;
    int amount;
    bit is_r, is_i;
    sa   = a;
    sav  = longint'($signed(a));
    sbv  = longint'($signed(b));
    is_r = (opc == 7'b0110011);
    is_i = (opc == 7'b0010011);
    if (is_r || is_i) begin
      amount = is_r ? int'(b[4:0]) : int'(sh);
      case (f3)
        3'd0: return (is_r && f7[5]) ? a - b : a + b;
        3'd1: return a << amount;
        3'd2: return (sav < sbv) ? 32'd1 : 32'd0;
        3'd3: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return f7[5] ? 32'(sa >>> amount) : a >> amount;
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    if (opc inside {7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0010111}) return a + b;
    if (opc == 7'b0110111) return b;
    if (opc == 7'b1100011) return a - b;
    return 32'd0;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, longint'($signed(a)) < longint'($signed(b)), {32'd0, a} < {32'd0, b}};
  endfunction

  // Apply one instruction; outputs must hold until the edge, then show it one cycle later.
  task automatic step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q);
    logic [2:0] fl;
    opcode = opc; func3 = f3; func7 = f7; shamt = sh; A = a; B = b;
    #1;
    check({tag, ":hold"}, Q, prev_q);
    check({tag, ":hold_flags"}, {29'd0, EQ, EQM, EQM_U}, {29'd0, prev_flags});
    @(posedge clk); #1;
    fl = ref_flags(a, b);
    check(tag, Q, exp_q);
    check({tag, ":EQ"},    {31'd0, EQ},    {31'd0, fl[2]});
    check({tag, ":EQM"},   {31'd0, EQM},   {31'd0, fl[1]});
    check({tag, ":EQM_U"}, {31'd0, EQM_U}, {31'd0, fl[0]});
    prev_q = exp_q;
    prev_flags = fl;
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011;
  localparam logic [6:0] F7N = 7'b0000000, F7A = 7'b0100000;

  initial begin
    logic [6:0]  opcs [11];
    logic [31:0] edges [6];
    logic [6:0]  o, f7r;
    logic [2:0]  f3r;
    logic [4:0]  shr;
    logic [31:0] ar, br;

    opcs  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111};
    edges = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
              32'h0000_0001, 32'h0000_001F};

    // Reset with non-trivial inputs present
    rst_n = 1'b0;
    opcode = R; func3 = 3'd0; func7 = F7N; shamt = 5'd0;
    A = 32'hFFFF_FFFF; B = 32'h0000_0001;
    @(posedge clk); @(posedge clk); #1;
    check("reset_q", Q, 32'd0);
    check("reset_flags", {29'd0, EQ, EQM, EQM_U}, 32'd0);
    prev_q = 32'd0;
    prev_flags = 3'b000;
    rst_n = 1'b1;

    step("add",  R, 3'd0, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0003);
    step("sub",  R, 3'd0, F7A, 5'd0, 32'd1, 32'd2, 32'hFFFF_FFFF);
    step("and",  R, 3'd7, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0000);
    step("or",   R, 3'd6, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0003);
    step("xor",  R, 3'd4, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0003);
    step("sll",  R, 3'd1, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0004);
    step("srl",  R, 3'd5, F7N, 5'd0, 32'd1, 32'd2, 32'h0000_0000);
    step("sra",  R, 3'd5, F7A, 5'd0, 32'h8000_0000, 32'd4, 32'hF800_0000);
    step("srl_msb", R, 3'd5, F7N, 5'd0, 32'h8000_0000, 32'd4, 32'h0800_0000);
    step("sra_zero", R, 3'd5, F7A, 5'd0, 32'h8000_0000, 32'd0, 32'h8000_0000);
    step("slli", I, 3'd1, F7N, 5'd1, 32'd1, 32'd0, 32'h0000_0002);
    step("srai31", I, 3'd5, F7A, 5'd31, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
    step("slt",  R, 3'd2, F7N, 5'd0, 32'hFFFF_FFF9, 32'd6, 32'h0000_0001);
    step("sltu", R, 3'd3, F7N, 5'd0, 32'd2, 32'd3, 32'h0000_0001);
    step("sltu_neg", R, 3'd3, F7N, 5'd0, 32'hFFFF_FFF9, 32'd6, 32'h0000_0000);
    step("equal", R, 3'd0, F7N, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h2468_ACF0);
    step("addi_f7", I, 3'd0, F7A, 5'd0, 32'd5, 32'd3, 32'h0000_0008);
    step("lui",  7'b0110111, 3'd0, F7N, 5'd0, 32'd1, 32'hABCD_E000, 32'hABCD_E000);
    step("branch", 7'b1100011, 3'd0, F7N, 5'd0, 32'd5, 32'd7, 32'hFFFF_FFFE);
    step("unknown", 7'b1111111, 3'd0, F7N, 5'd0, 32'd5, 32'd7, 32'h0000_0000);

    // Reset mid-stream discards the pending result
    opcode = R; func3 = 3'd0; func7 = F7N; A = 32'd10; B = 32'd20; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_q", Q, 32'd0);
    check("midreset_flags", {29'd0, EQ, EQM, EQM_U}, 32'd0);
    rst_n = 1'b1;
    prev_q = 32'd0;
    prev_flags = 3'b000;

    // Randomized back-to-back traffic, a new instruction every cycle
    for (int i = 0; i < 300; i++) begin
      o   = opcs[$urandom_range(0, 10)];
      f3r = 3'($urandom_range(0, 7));
      f7r = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? F7A : F7N);
      shr = 5'($urandom);
      ar  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      br  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 5) == 0) br = ar;
      step($sformatf("rand%0d", i), o, f3r, f7r, shr, ar, br, ref_q(o, f3r, f7r, shr, ar, br));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
